// File: rtl/matmul_scheduler_pkg.sv
// Shared types for the matrix-multiply engine scheduler.
package matmul_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE_MS,
    CLEAR_MS,
    RUN_MS,
    DONE_MS,
    ABORT_MS
  } state_mmsched;

  // Increment modulo n, used to move the round-robin pointer past the last winner.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/matmul_scheduler_rr_pick.sv
// Round-robin picker: first set request bit at or after the pointer, wrapping.
module matmul_scheduler_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned       j;
  logic [IDX_W-1:0]  jj;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = 32'(rr_ptr) + 32'(i);
      if (j >= N_REQ) j = j - N_REQ;
      jj = IDX_W'(j);
      if (req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/matmul_scheduler.sv
// Round-robin scheduler sharing one matrix-multiply engine between N_REQ requesters,
// with an engine clear before each job and a RUN-phase watchdog.
module matmul_scheduler
  import matmul_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned IDX_W      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] err,
  output logic             busy,
  output logic             mm_clr,
  output logic             mm_start,
  input  logic             mm_f
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + CLR_CYCLES) + 1;

  state_mmsched     state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  matmul_scheduler_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE_MS;
      cnt      <= '0;
      rr_ptr   <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
      mm_clr   <= 1'b0;
      mm_start <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE_MS: begin
          if (pick_found) begin
            gnt     <= N_REQ'(1) << pick_idx;
            gnt_idx <= pick_idx;
            busy    <= 1'b1;
            mm_clr  <= 1'b1;
            cnt     <= '0;
            state   <= CLEAR_MS;
          end
        end
        // mm_f is deliberately ignored here: it still carries the previous job's finish.
        CLEAR_MS: begin
          if (cnt == CNT_W'(CLR_CYCLES - 1)) begin
            mm_clr   <= 1'b0;
            mm_start <= 1'b1;
            cnt      <= '0;
            state    <= RUN_MS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A finish seen on the timeout cycle still counts as success.
        RUN_MS: begin
          if (mm_f) begin
            mm_start      <= 1'b0;
            done[gnt_idx] <= 1'b1;
            state         <= DONE_MS;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mm_start     <= 1'b0;
            mm_clr       <= 1'b1;
            err[gnt_idx] <= 1'b1;
            state        <= ABORT_MS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_MS, ABORT_MS: begin
          mm_clr <= 1'b0;
          gnt    <= '0;
          busy   <= 1'b0;
          cnt    <= '0;
          rr_ptr <= IDX_W'(wrap_inc(32'(gnt_idx), N_REQ));
          state  <= IDLE_MS;
        end
        default: state <= IDLE_MS;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a behavioural engine model (TIMEOUT=16).
module tb_matmul_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, done, err;
  logic [1:0] gnt_idx;
  logic       busy, mm_clr, mm_start, mm_f;

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   multihot   = 0;
  int   fa         = 0;   // engine finishes in this RUN cycle; 0 = never
  logic stale_hold = 1'b0;
  logic eng_sticky;
  int   eng_cnt;
  int   cyc;

  matmul_scheduler #(
    .N_REQ      (4),
    .CLR_CYCLES (2),
    .TIMEOUT    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .mm_clr   (mm_clr),
    .mm_start (mm_start),
    .mm_f     (mm_f)
  );

  always #5 clk = ~clk;

  // Engine: counts enabled cycles, finishes in cycle fa and stays finished until cleared.
  always @(posedge clk) begin
    if (rst || mm_clr) begin
      eng_cnt    <= 0;
      eng_sticky <= 1'b0;
    end else if (mm_start) begin
      eng_cnt <= eng_cnt + 1;
      if (fa != 0 && eng_cnt == fa - 1) eng_sticky <= 1'b1;
    end
  end

  assign mm_f = stale_hold | eng_sticky | (mm_start && fa != 0 && eng_cnt == fa - 1);

  always @(negedge clk) if ($countones(gnt) > 1) multihot++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns the number of negedges until done or err is seen, or -1 if none in budget.
  task automatic wait_end(output int c);
    c = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (mm_start) stale_hold = 1'b0;
      if ((done | err) != 4'b0000) begin
        c = k;
        break;
      end
    end
  endtask

  // Expects req already driven at an IDLE negedge; returns at the done/err negedge.
  task automatic do_job(input string tag, input int idx, input int cyc_exp, input logic is_err);
    int c;
    logic [3:0] oh;
    oh = 4'(1) << idx;
    step();
    check({tag, " gnt"}, 32'(gnt), 32'(oh));
    check({tag, " gnt_idx"}, 32'(gnt_idx), 32'(idx));
    wait_end(c);
    check({tag, " latency"}, 32'(c), 32'(cyc_exp));
    check({tag, " gnt held"}, 32'(gnt), 32'(oh));
    if (is_err) begin
      check({tag, " err"}, 32'(err), 32'(oh));
      check({tag, " no done"}, 32'(done), 32'd0);
      check({tag, " abort clr"}, 32'(mm_clr), 32'd1);
    end else begin
      check({tag, " done"}, 32'(done), 32'(oh));
      check({tag, " no err"}, 32'(err), 32'd0);
    end
    check({tag, " start low"}, 32'(mm_start), 32'd0);
  endtask

  initial begin
    // Reset values
    step(); step();
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset gnt_idx", 32'(gnt_idx), 32'd0);
    check("reset done/err", 32'({done, err}), 32'd0);
    check("reset busy/clr/start", 32'({busy, mm_clr, mm_start}), 32'd0);
    rst = 1'b0;
    step();

    // Single request on 2: grant next cycle, two clear cycles, then start
    fa  = 10;
    req = 4'b0100;
    step();
    check("t1 gnt", 32'(gnt), 32'h4);
    check("t1 gnt_idx", 32'(gnt_idx), 32'd2);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 clr cycle1", 32'({mm_clr, mm_start}), 32'b10);
    step();
    check("t1 clr cycle2", 32'({mm_clr, mm_start}), 32'b10);
    step();
    check("t1 run", 32'({mm_clr, mm_start}), 32'b01);
    wait_end(cyc);
    check("t1 run cycles to done", 32'(cyc), 32'd10);
    check("t1 done", 32'(done), 32'h4);
    check("t1 err", 32'(err), 32'd0);
    req = 4'b0000;
    step();
    check("t1 idle", 32'({busy, gnt, done}), 32'd0);

    // Pointer now 3: requesters 0 and 3 pending, 3 must win
    req = 4'b1001;
    do_job("ptr3", 3, 12, 1'b0);
    req = 4'b0000;
    step();
    check("ptr3 idle", 32'(busy), 32'd0);

    // All requesting continuously: 0,1,2,3,0 with an idle gap between jobs
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      do_job("rr", j % 4, 12, 1'b0);
      if (j == 4) req = 4'b0000;
      step();
      check("rr gap", 32'({busy, gnt, done}), 32'd0);
    end

    // Stale finish held through CLEAR must not end the job early
    stale_hold = 1'b1;
    fa  = 5;
    req = 4'b0010;
    do_job("stale", 1, 7, 1'b0);
    req = 4'b0000;
    step();

    // Hung engine: abort after 16 RUN cycles, then requester 1 is served
    fa  = 0;
    req = 4'b0110;
    do_job("abort", 2, 18, 1'b0 ^ 1'b1);
    req = 4'b0010;
    step();
    check("abort idle", 32'({busy, mm_clr, err}), 32'd0);
    fa = 10;
    do_job("after abort", 1, 12, 1'b0);
    req = 4'b0000;
    step();

    // Request dropped mid-RUN still completes
    req = 4'b0010;
    step();
    check("drop gnt", 32'(gnt), 32'h2);
    step(); step(); step();
    check("drop in run", 32'(mm_start), 32'd1);
    req = 4'b0000;
    wait_end(cyc);
    check("drop remaining cycles", 32'(cyc), 32'd9);
    check("drop done", 32'(done), 32'h2);
    step();

    // Finish on the timeout cycle counts as done
    fa  = 16;
    req = 4'b0100;
    do_job("coincide", 2, 18, 1'b0);
    req = 4'b0000;
    step();

    // Async reset in RUN clears everything at once, pointer included
    fa  = 0;
    req = 4'b1000;
    step();
    check("rst gnt", 32'(gnt), 32'h8);
    repeat (6) step();
    check("rst in run", 32'(mm_start), 32'd1);
    rst = 1'b1;
    #1;
    check("rst async gnt/idx", 32'({gnt, gnt_idx}), 32'd0);
    check("rst async outs", 32'({done, err, busy, mm_clr, mm_start}), 32'd0);
    req = 4'b0000;
    step(); step();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("rst no pulse", 32'({done, err, busy}), 32'd0);
    end
    req = 4'b1111;
    fa  = 10;
    do_job("post reset", 0, 12, 1'b0);
    req = 4'b0000;
    step();

    check("gnt one-hot", 32'(multihot), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
